// File: rtl/dma_desc_pkg.sv
// Shared definitions for the DMA descriptor agent: register word map,
// magic values and the sequencing FSM state encoding.
package dma_desc_pkg;

  // Peripheral register word offsets (byte address = base + 4*word)
  localparam logic [3:0] W_EVT     = 4'd0;   // event FIFO pop
  localparam logic [3:0] W_LEN     = 4'd1;   // RX length of popped event
  localparam logic [3:0] W_RX_SIZE = 4'd2;   // RX buffer size
  localparam logic [3:0] W_RX_ADDR = 4'd3;   // RX buffer address (pushes buffer)
  localparam logic [3:0] W_TX_CTRL = 4'd4;   // TX {tag,len}
  localparam logic [3:0] W_TX_ADDR = 4'd5;   // TX address (submits packet)
  localparam logic [3:0] W_RSVD6   = 4'd6;
  localparam logic [3:0] W_CTRL    = 4'd7;   // guard / enable
  localparam logic [3:0] W_RSVD8   = 4'd8;
  localparam logic [3:0] W_RSVD9   = 4'd9;
  localparam logic [3:0] W_RSVD10  = 4'd10;
  localparam logic [3:0] W_RSVD11  = 4'd11;
  localparam logic [3:0] W_RSVD12  = 4'd12;
  localparam logic [3:0] W_RSVD13  = 4'd13;

  localparam logic [15:0] GUARD    = 16'h1234;
  localparam logic [31:0] EMPTY    = 32'h8000_0000;
  localparam logic [31:0] START_EN = 32'h0000_0001;

  typedef enum logic [3:0] {
    IDLE, START_G, START_E, PRE_L, PRE_A, POLL,
    RD_LEN, CMPL, REF_L, REF_A, TX_L, TX_A
  } state_e;

  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [3:0]  word);
    return base + {26'b0, word, 2'b00};
  endfunction

endpackage

// File: rtl/dma_desc_agent_peri_port.sv
// Single-outstanding peripheral access engine: turns a request into a
// one-cycle strobe, then waits for ready or a down-counter timeout.
module peri_access_port
  import dma_desc_pkg::*;
#(
  parameter logic [31:0] PERI_BASE = 32'h1000_4000,
  parameter int          TIMEOUT   = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [3:0]  req_word,
  input  logic [31:0] req_wdata,
  output logic        o_peri_rden,
  output logic        o_peri_wren,
  output logic [31:0] o_peri_addr,
  output logic [31:0] o_peri_wdata,
  input  logic        i_peri_ready,
  output logic        pending,
  output logic        done,
  output logic        timeout
);

  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT);

  logic [15:0] tmr;

  // Ready is accepted from the strobe cycle on; timeout fires when the
  // counter has run out and ready is still absent.
  assign done    = pending & i_peri_ready;
  assign timeout = pending & ~i_peri_ready & (tmr == 16'd0);

  // Strobe issue, outstanding flag and timeout counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_peri_rden  <= 1'b0;
      o_peri_wren  <= 1'b0;
      o_peri_addr  <= '0;
      o_peri_wdata <= '0;
      pending      <= 1'b0;
      tmr          <= '0;
    end else begin
      o_peri_rden <= 1'b0;
      o_peri_wren <= 1'b0;
      if (!pending && (req_rd || req_wr)) begin
        o_peri_rden  <= req_rd;
        o_peri_wren  <= req_wr & ~req_rd;
        o_peri_addr  <= word_addr(PERI_BASE, req_word);
        o_peri_wdata <= req_rd ? 32'd0 : req_wdata;
        pending      <= 1'b1;
        tmr          <= TMO_LOAD;
      end else if (pending) begin
        if (i_peri_ready || tmr == 16'd0) pending <= 1'b0;
        else                              tmr     <= tmr - 16'd1;
      end
    end
  end

endmodule

// File: rtl/dma_desc_agent.sv
// DMA descriptor agent: starts the DMA peripheral, keeps it stocked with
// RX buffers, forwards RX completions and TX submissions.
//
// state   | meaning
// IDLE    | waiting; arbitrates event > free buffer > TX submit
// START_G | write guard word to CTRL
// START_E | write enable to CTRL
// PRE_L   | prefill: write RX buffer size
// PRE_A   | prefill: write RX buffer address, advance k
// POLL    | read event word
// RD_LEN  | read RX length
// CMPL    | present completion until accepted
// REF_L   | refill: write RX buffer size
// REF_A   | refill: write returned buffer address
// TX_L    | write TX {tag,len}
// TX_A    | write TX address
module dma_desc_agent
  import dma_desc_pkg::*;
#(
  parameter logic [31:0] PERI_BASE = 32'h1000_4000,
  parameter logic [31:0] RX_BASE   = 32'h0001_0000,
  parameter logic [15:0] RX_SIZE   = 16'd2048,
  parameter int          NUM_RX    = 4,
  parameter int          TIMEOUT   = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  output logic        o_peri_rden,
  output logic        o_peri_wren,
  output logic [31:0] o_peri_addr,
  output logic [31:0] o_peri_wdata,
  input  logic [31:0] i_peri_rdata,
  input  logic        i_peri_ready,
  input  logic        i_peri_int,
  output logic        o_cmpl_valid,
  output logic [31:0] o_cmpl_addr,
  output logic [15:0] o_cmpl_len,
  input  logic        i_cmpl_ready,
  input  logic        i_free_valid,
  input  logic [31:0] i_free_addr,
  output logic        o_free_ready,
  input  logic        i_tx_valid,
  input  logic [31:0] i_tx_addr,
  input  logic [15:0] i_tx_len,
  input  logic [3:0]  i_tx_tag,
  output logic        o_tx_ready,
  output logic        o_tx_done,
  output logic        o_started,
  output logic        o_busy,
  output logic        o_err_timeout,
  output logic        o_err_proto
);

  localparam logic [3:0]  LAST_K  = 4'(NUM_RX - 1);
  localparam logic [31:0] SIZE_WD = {16'b0, RX_SIZE};

  state_e      state, state_nx;
  logic        req_rd, req_wr;
  logic [3:0]  req_word;
  logic [31:0] req_wdata;
  logic        acc_pending, acc_done, acc_tmo;
  logic        en_q;
  logic [3:0]  pre_k;
  logic [31:0] pre_addr;
  logic [31:0] ref_addr;
  logic [31:0] tx_addr;
  logic [15:0] tx_len;
  logic [3:0]  tx_tag;
  logic        rd_empty;

  assign rd_empty     = (i_peri_rdata == EMPTY);
  assign o_busy       = (state != IDLE);
  assign o_cmpl_valid = (state == CMPL);

  peri_access_port #(
    .PERI_BASE (PERI_BASE),
    .TIMEOUT   (TIMEOUT)
  ) u_port (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .req_rd       (req_rd),
    .req_wr       (req_wr),
    .req_word     (req_word),
    .req_wdata    (req_wdata),
    .o_peri_rden  (o_peri_rden),
    .o_peri_wren  (o_peri_wren),
    .o_peri_addr  (o_peri_addr),
    .o_peri_wdata (o_peri_wdata),
    .i_peri_ready (i_peri_ready),
    .pending      (acc_pending),
    .done         (acc_done),
    .timeout      (acc_tmo)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next state and access request per state; the port ignores the request
  // while an access is outstanding, so holding it is harmless.
  always_comb begin
    state_nx  = state;
    req_rd    = 1'b0;
    req_wr    = 1'b0;
    req_word  = W_EVT;
    req_wdata = '0;
    case (state)
      IDLE: begin
        if (i_en && !en_q && !o_started) state_nx = START_G;
        else if (i_en && o_started) begin
          if      (i_peri_int)   state_nx = POLL;
          else if (i_free_valid) state_nx = REF_L;
          else if (i_tx_valid)   state_nx = TX_L;
        end
      end
      START_G: begin
        req_wr = 1'b1; req_word = W_CTRL; req_wdata = {16'b0, GUARD};
        if (acc_done) state_nx = START_E;
      end
      START_E: begin
        req_wr = 1'b1; req_word = W_CTRL; req_wdata = START_EN;
        if (acc_done) state_nx = PRE_L;
      end
      PRE_L: begin
        req_wr = 1'b1; req_word = W_RX_SIZE; req_wdata = SIZE_WD;
        if (acc_done) state_nx = PRE_A;
      end
      PRE_A: begin
        req_wr = 1'b1; req_word = W_RX_ADDR; req_wdata = pre_addr;
        if (acc_done) state_nx = (pre_k == LAST_K) ? IDLE : PRE_L;
      end
      POLL: begin
        req_rd = 1'b1; req_word = W_EVT;
        if (acc_done) state_nx = (!rd_empty && i_peri_rdata[31]) ? RD_LEN : IDLE;
      end
      RD_LEN: begin
        req_rd = 1'b1; req_word = W_LEN;
        if (acc_done) state_nx = rd_empty ? IDLE : CMPL;
      end
      CMPL: begin
        if (i_cmpl_ready) state_nx = IDLE;
      end
      REF_L: begin
        req_wr = 1'b1; req_word = W_RX_SIZE; req_wdata = SIZE_WD;
        if (acc_done) state_nx = REF_A;
      end
      REF_A: begin
        req_wr = 1'b1; req_word = W_RX_ADDR; req_wdata = ref_addr;
        if (acc_done) state_nx = IDLE;
      end
      TX_L: begin
        req_wr = 1'b1; req_word = W_TX_CTRL; req_wdata = {12'b0, tx_tag, tx_len};
        if (acc_done) state_nx = TX_A;
      end
      TX_A: begin
        req_wr = 1'b1; req_word = W_TX_ADDR; req_wdata = tx_addr;
        if (acc_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (acc_tmo) state_nx = IDLE;
  end

  // Flags, handshake pulses and latched request/response data
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en_q          <= 1'b0;
      o_started     <= 1'b0;
      o_err_timeout <= 1'b0;
      o_err_proto   <= 1'b0;
      o_free_ready  <= 1'b0;
      o_tx_ready    <= 1'b0;
      o_tx_done     <= 1'b0;
      o_cmpl_addr   <= '0;
      o_cmpl_len    <= '0;
      pre_k         <= '0;
      pre_addr      <= '0;
      ref_addr      <= '0;
      tx_addr       <= '0;
      tx_len        <= '0;
      tx_tag        <= '0;
    end else begin
      en_q         <= i_en;
      o_free_ready <= (state == IDLE) && (state_nx == REF_L);
      o_tx_ready   <= (state == IDLE) && (state_nx == TX_L);
      o_tx_done    <= (state == POLL) && acc_done && !i_peri_rdata[31];
      if (acc_tmo) o_err_timeout <= 1'b1;
      if (state == START_E && acc_done) o_started <= 1'b1;
      if (state == RD_LEN && acc_done && rd_empty) o_err_proto <= 1'b1;
      if (state == IDLE && state_nx == START_G) begin
        pre_k    <= '0;
        pre_addr <= RX_BASE;
      end
      if (state == PRE_A && acc_done) begin
        pre_k    <= pre_k + 4'd1;
        pre_addr <= pre_addr + SIZE_WD;
      end
      if (state == POLL && acc_done && !rd_empty && i_peri_rdata[31])
        o_cmpl_addr <= {1'b0, i_peri_rdata[30:0]};
      if (state == RD_LEN && acc_done && !rd_empty)
        o_cmpl_len <= i_peri_rdata[15:0];
      if (state == IDLE && state_nx == REF_L) ref_addr <= i_free_addr;
      if (state == IDLE && state_nx == TX_L) begin
        tx_addr <= i_tx_addr;
        tx_len  <= i_tx_len;
        tx_tag  <= i_tx_tag;
      end
    end
  end

endmodule

// File: tb/tb_dma_desc_agent.sv
// Scoreboard bench for dma_desc_agent: stimulus pushes expected peripheral
// accesses / completions into a queue, a monitor pops and compares them.
module tb_dma_desc_agent;

  localparam logic [31:0] PB = 32'h1000_4000;
  localparam int K_WR = 0, K_RD = 1, K_CMPL = 2, K_TXD = 3;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_en;
  logic        o_peri_rden, o_peri_wren;
  logic [31:0] o_peri_addr, o_peri_wdata, i_peri_rdata;
  logic        i_peri_ready, i_peri_int;
  logic        o_cmpl_valid, i_cmpl_ready;
  logic [31:0] o_cmpl_addr;
  logic [15:0] o_cmpl_len;
  logic        i_free_valid, o_free_ready;
  logic [31:0] i_free_addr;
  logic        i_tx_valid, o_tx_ready;
  logic [31:0] i_tx_addr;
  logic [15:0] i_tx_len;
  logic [3:0]  i_tx_tag;
  logic        o_tx_done, o_started, o_busy, o_err_timeout, o_err_proto;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rd_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_popped = 0;
  int          pop_target = 0;
  logic        withhold = 1'b0;

  always #5 i_clk = ~i_clk;

  dma_desc_agent #(.NUM_RX(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en),
    .o_peri_rden(o_peri_rden), .o_peri_wren(o_peri_wren),
    .o_peri_addr(o_peri_addr), .o_peri_wdata(o_peri_wdata),
    .i_peri_rdata(i_peri_rdata), .i_peri_ready(i_peri_ready), .i_peri_int(i_peri_int),
    .o_cmpl_valid(o_cmpl_valid), .o_cmpl_addr(o_cmpl_addr), .o_cmpl_len(o_cmpl_len),
    .i_cmpl_ready(i_cmpl_ready),
    .i_free_valid(i_free_valid), .i_free_addr(i_free_addr), .o_free_ready(o_free_ready),
    .i_tx_valid(i_tx_valid), .i_tx_addr(i_tx_addr), .i_tx_len(i_tx_len),
    .i_tx_tag(i_tx_tag), .o_tx_ready(o_tx_ready),
    .o_tx_done(o_tx_done), .o_started(o_started), .o_busy(o_busy),
    .o_err_timeout(o_err_timeout), .o_err_proto(o_err_proto)
  );

  task automatic push(input int kind, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.kind = kind; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_cmp(input int kind, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    n_tests++;
    n_popped++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_output: kind %0d addr %h data %h, nothing expected", kind, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.addr !== a || e.data !== d) begin
        n_fail++;
        $display("FAIL sb_item: got kind %0d addr %h data %h expected kind %0d addr %h data %h",
                 kind, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  // Monitor: every DUT output event is compared with the scoreboard head
  initial begin
    forever begin
      @(negedge i_clk);
      if (i_rst_n) begin
        if (o_peri_wren) sb_cmp(K_WR, o_peri_addr, o_peri_wdata);
        if (o_peri_rden) sb_cmp(K_RD, o_peri_addr, 32'd0);
        if (o_cmpl_valid && i_cmpl_ready) sb_cmp(K_CMPL, o_cmpl_addr, {16'b0, o_cmpl_len});
        if (o_tx_done) sb_cmp(K_TXD, 32'd0, 32'd0);
      end
    end
  end

  // Peripheral model: answers each strobe one cycle later, reads pop rd_q
  initial begin
    logic is_rd;
    i_peri_ready = 1'b0;
    i_peri_rdata = '0;
    forever begin
      @(negedge i_clk);
      if ((o_peri_rden || o_peri_wren) && !withhold) begin
        is_rd = o_peri_rden;
        @(posedge i_clk); #1;
        i_peri_ready = 1'b1;
        if (is_rd) i_peri_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h8000_0000;
        @(posedge i_clk); #1;
        i_peri_ready = 1'b0;
      end
    end
  end

  function automatic logic cond(input int sel);
    case (sel)
      0: return (exp_q.size() == 0) && !o_busy;
      1: return o_busy;
      2: return o_free_ready;
      3: return o_tx_ready;
      4: return o_cmpl_valid;
      5: return o_peri_rden;
      6: return n_popped >= pop_target;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_until(input int sel, input int budget, input string what);
    int n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!cond(sel) && n < budget);
    if (!cond(sel)) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_%s: condition not reached within %0d cycles", what, budget);
    end
  endtask

  task automatic tick;
    @(posedge i_clk); #1;
  endtask

  task automatic push_start;
    push(K_WR, PB + 32'h1C, 32'h0000_1234);
    push(K_WR, PB + 32'h1C, 32'h0000_0001);
    push(K_WR, PB + 32'h08, 32'h0000_0800);
    push(K_WR, PB + 32'h0C, 32'h0001_0000);
    push(K_WR, PB + 32'h08, 32'h0000_0800);
    push(K_WR, PB + 32'h0C, 32'h0001_0800);
  endtask

  task automatic fire_int;
    tick; i_peri_int = 1'b1;
    wait_until(1, 20, "busy_poll");
    tick; i_peri_int = 1'b0;
  endtask

  initial begin
    int n;
    i_rst_n = 1'b0; i_en = 1'b0; i_peri_int = 1'b0; i_cmpl_ready = 1'b0;
    i_free_valid = 1'b0; i_free_addr = '0;
    i_tx_valid = 1'b0; i_tx_addr = '0; i_tx_len = '0; i_tx_tag = '0;
    repeat (3) @(negedge i_clk);
    check("rst_started", {31'b0, o_started}, 32'd0);
    check("rst_busy", {31'b0, o_busy}, 32'd0);
    check("rst_strobes", {30'b0, o_peri_rden, o_peri_wren}, 32'd0);
    check("rst_errs", {30'b0, o_err_timeout, o_err_proto}, 32'd0);
    check("rst_cmpl_valid", {31'b0, o_cmpl_valid}, 32'd0);
    tick; i_rst_n = 1'b1;
    repeat (3) tick;

    // Start + prefill of two buffers
    push_start();
    i_en = 1'b1;
    wait_until(0, 200, "start_done");
    check("started", {31'b0, o_started}, 32'd1);

    // RX completion with three stall cycles
    rd_q.push_back(32'h8001_2000); rd_q.push_back(32'h0000_0040);
    push(K_RD, PB + 32'h00, 32'd0);
    push(K_RD, PB + 32'h04, 32'd0);
    push(K_CMPL, 32'h0001_2000, 32'h0000_0040);
    fire_int();
    wait_until(4, 50, "cmpl_valid");
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check("cmpl_hold_valid", {31'b0, o_cmpl_valid}, 32'd1);
      check("cmpl_hold_addr", o_cmpl_addr, 32'h0001_2000);
      check("cmpl_hold_len", {16'b0, o_cmpl_len}, 32'h0000_0040);
    end
    tick; i_cmpl_ready = 1'b1;
    tick; i_cmpl_ready = 1'b0;
    wait_until(0, 50, "cmpl_idle");

    // Priority: event poll, then refill, then TX
    rd_q.push_back(32'h8000_0000);
    push(K_RD, PB + 32'h00, 32'd0);
    push(K_WR, PB + 32'h08, 32'h0000_0800);
    push(K_WR, PB + 32'h0C, 32'h0001_1000);
    push(K_WR, PB + 32'h10, 32'h0003_0100);
    push(K_WR, PB + 32'h14, 32'h0000_2000);
    tick;
    i_peri_int = 1'b1; i_free_valid = 1'b1; i_free_addr = 32'h0001_1000;
    i_tx_valid = 1'b1; i_tx_addr = 32'h0000_2000; i_tx_len = 16'h0100; i_tx_tag = 4'd3;
    wait_until(1, 20, "busy_prio");
    tick; i_peri_int = 1'b0;
    wait_until(2, 50, "free_ready");
    tick; i_free_valid = 1'b0;
    wait_until(3, 50, "tx_ready");
    tick; i_tx_valid = 1'b0;
    wait_until(0, 100, "prio_idle");

    // TX-done event, then empty FIFO
    rd_q.push_back(32'h0000_3000);
    push(K_RD, PB + 32'h00, 32'd0);
    push(K_TXD, 32'd0, 32'd0);
    fire_int();
    wait_until(0, 50, "txdone_idle");
    rd_q.push_back(32'h8000_0000);
    push(K_RD, PB + 32'h00, 32'd0);
    fire_int();
    wait_until(0, 50, "empty_idle");
    repeat (3) @(negedge i_clk);
    check("no_err_after_empty", {30'b0, o_err_timeout, o_err_proto}, 32'd0);

    // Length word reads back EMPTY -> protocol error
    rd_q.push_back(32'h8001_2000); rd_q.push_back(32'h8000_0000);
    push(K_RD, PB + 32'h00, 32'd0);
    push(K_RD, PB + 32'h04, 32'd0);
    fire_int();
    wait_until(0, 50, "proto_idle");
    check("err_proto", {31'b0, o_err_proto}, 32'd1);

    // Ready withheld: timeout after 256 cycles, then normal recovery
    withhold = 1'b1;
    push(K_RD, PB + 32'h00, 32'd0);
    fire_int();
    wait_until(5, 20, "tmo_strobe");
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_err_timeout && n < 400);
    check("tmo_cycles", n, 32'd256);
    check("tmo_flag", {31'b0, o_err_timeout}, 32'd1);
    check("tmo_idle", {31'b0, o_busy}, 32'd0);
    withhold = 1'b0;
    rd_q.push_back(32'h8000_0000);
    push(K_RD, PB + 32'h00, 32'd0);
    fire_int();
    wait_until(0, 50, "tmo_recover");
    check("tmo_sticky", {31'b0, o_err_timeout}, 32'd1);

    // Later i_en edges never replay the start sequence
    tick; i_en = 1'b0;
    repeat (3) tick;
    i_en = 1'b1;
    repeat (10) @(negedge i_clk);
    check("no_restart_busy", {31'b0, o_busy}, 32'd0);

    // Reset in the middle of prefill, then full replay
    tick; i_rst_n = 1'b0; i_en = 1'b0;
    repeat (3) tick;
    i_rst_n = 1'b1;
    repeat (2) tick;
    push_start();
    pop_target = n_popped + 3;
    i_en = 1'b1;
    wait_until(6, 100, "mid_prefill");
    @(posedge i_clk); #2;
    i_rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, o_busy}, 32'd0);
    check("midrst_started", {31'b0, o_started}, 32'd0);
    check("midrst_errs", {30'b0, o_err_timeout, o_err_proto}, 32'd0);
    check("midrst_strobes", {30'b0, o_peri_rden, o_peri_wren}, 32'd0);
    check("midrst_addr", o_peri_addr, 32'd0);
    exp_q.delete();
    rd_q.delete();
    i_en = 1'b0;
    repeat (4) tick;
    i_rst_n = 1'b1;
    repeat (3) tick;
    push_start();
    i_en = 1'b1;
    wait_until(0, 200, "replay_done");
    check("replay_started", {31'b0, o_started}, 32'd1);
    repeat (5) @(negedge i_clk);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dma_desc_agent.md
DMA_DESC_AGENT -- requirements
Module: dma_desc_agent

Interface
REQ-001 SHALL have parameter PERI_BASE, default 32'h1000_4000, the byte base address of the DMA peripheral register window.
REQ-002 SHALL have parameter RX_BASE, default 32'h0001_0000, the byte address of RX buffer 0.
REQ-003 SHALL have parameter RX_SIZE, default 16'd2048, the byte size of each RX buffer.
REQ-004 SHALL have parameter NUM_RX, default 4, the number of RX buffers (range 1..16).
REQ-005 SHALL have parameter TIMEOUT, default 255, the maximum cycles to wait for ready.
REQ-006 SHALL have port i_clk, input, 1 bit: clock.
REQ-007 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port i_en, input, 1 bit: agent enable.
REQ-009 SHALL have ports o_peri_rden and o_peri_wren, output, 1 bit each: one-cycle access strobes.
REQ-010 SHALL have ports o_peri_addr and o_peri_wdata, output, 32 bits each.
REQ-011 SHALL have ports i_peri_rdata (input, 32), i_peri_ready (input, 1) and i_peri_int (input, 1): event FIFO non-empty.
REQ-012 SHALL have ports o_cmpl_valid (output, 1), o_cmpl_addr (output, 32), o_cmpl_len (output, 16) and i_cmpl_ready (input, 1): received-packet stream.
REQ-013 SHALL have ports i_free_valid (input, 1), i_free_addr (input, 32) and o_free_ready (output, 1): returned RX buffer.
REQ-014 SHALL have ports i_tx_valid (input, 1), i_tx_addr (input, 32), i_tx_len (input, 16), i_tx_tag (input, 4) and o_tx_ready (output, 1): TX submit.
REQ-015 SHALL have outputs o_tx_done (1, one-cycle pulse), o_started (1), o_busy (1), o_err_timeout (1, sticky) and o_err_proto (1, sticky).

Function
REQ-016 SHALL keep at most one access outstanding: assert a strobe for exactly one cycle with addr = PERI_BASE + 4*word, then issue nothing until i_peri_ready.
REQ-017 SHALL capture i_peri_rdata in the cycle i_peri_ready is high after a read strobe.
REQ-018 SHALL, when no ready arrives within TIMEOUT cycles of a strobe, set o_err_timeout, abandon the sequence and return to IDLE.
REQ-019 SHALL, on the first i_en rise after reset, write word7=0x1234, then word7=0x1, set o_started, then prefill buffers k=0..NUM_RX-1.
REQ-020 SHALL prefill each buffer by writing word2={16'b0,RX_SIZE}, then word3=RX_BASE+k*RX_SIZE (32-bit wrap).
REQ-021 SHALL use FSM states IDLE, START_G, START_E, PRE_L, PRE_A, POLL, RD_LEN, CMPL, REF_L, REF_A, TX_L and TX_A.
REQ-022 SHALL, in IDLE with i_en=1 and o_started=1, select in priority order: i_peri_int -> POLL, i_free_valid -> REF_L, i_tx_valid -> TX_L.
REQ-023 SHALL, in POLL, read word0; rdata=0x8000_0000 means empty -> IDLE.
REQ-024 SHALL, in POLL, treat rdata[31]=1 as an RX event -> RD_LEN, with latched addr={1'b0,rdata[30:0]}.
REQ-025 SHALL, in POLL, treat rdata[31]=0 as a TX event: pulse o_tx_done for one cycle -> IDLE.
REQ-026 SHALL, in RD_LEN, read word1; rdata=0x8000_0000 sets o_err_proto -> IDLE.
REQ-027 SHALL, in RD_LEN with valid data, latch len=rdata[15:0] -> CMPL.
REQ-028 SHALL hold o_cmpl_valid and its data stable in CMPL until i_cmpl_ready, then go to IDLE.
REQ-029 SHALL pulse o_free_ready in the cycle REF_L is entered, latching i_free_addr; REF_L/REF_A write word2={16'b0,RX_SIZE}, word3=addr.
REQ-030 SHALL pulse o_tx_ready on TX_L entry, latching the request; TX_L writes word4={12'b0,tag,len}, TX_A writes word5=addr.
REQ-031 SHALL take i_en deassertion effect only in IDLE, never aborting an in-progress sequence.
REQ-032 SHALL NOT re-send the start sequence on later i_en edges.
REQ-033 SHALL assert o_busy whenever the FSM is not IDLE.

Reset
REQ-034 SHALL on i_rst_n low immediately force the FSM to IDLE, clear o_started, both error flags, all strobes, valids, readies and o_tx_done, and zero all addr/data/counters.

Structure
REQ-035 SHALL place in shared package dma_desc_pkg: word offsets 0..13, GUARD=16'h1234, EMPTY=32'h8000_0000 and the state enum.
REQ-036 SHALL put the strobe/ready/timeout engine in one sub-module, peri_access_port.

Verification
REQ-037 SHALL check: i_en rise with NUM_RX=2 -> writes w7=0x1234, w7=1, w2=0x800, w3=0x10000, w2=0x800, w3=0x10800; o_started=1.
REQ-038 SHALL check: i_peri_int with w0=0x8001_2000, w1=0x40 -> o_cmpl_valid addr=0x0001_2000 len=0x40, held through 3 stall cycles.
REQ-039 SHALL check: i_peri_int, i_free_valid and i_tx_valid together -> POLL first, then REF, then TX (w4=0x0003_0100, w5=0x2000 for tag 3, len 0x100).
REQ-040 SHALL check: w0=0x0000_3000 -> single o_tx_done pulse, no cmpl; then w0=0x8000_0000 -> IDLE, no error.
REQ-041 SHALL check: ready withheld 256 cycles -> o_err_timeout=1, FSM IDLE, next access proceeds normally.
REQ-042 SHALL check: i_rst_n low mid-prefill -> all outputs zero at once; i_en rise after release replays the full start sequence.
